set_host: RTL

Host-side driver for the `SET` candidate-counting engine. It queues circle-set jobs from an upstream source and launches each one on the `SET` `en`/`central`/`radius`/`mode` interface. It collects the `valid`/`candidate` response and returns it downstream with the job tag, plus a timeout flag. It sits between the job source (pattern ROM or CPU bridge) and one `SET` instance.

---
 rtl/set_pkg.sv | 32 +++
 rtl/set_job_fifo.sv | 68 ++++++
 rtl/set_host.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// Shared types and constants for the SET host driver.
// Holds the job payload layout, field widths, mode encodings and FSM states.
package set_pkg;

  localparam int unsigned COORD_W   = 4;
  localparam int unsigned CENTRAL_W = 6 * COORD_W;
  localparam int unsigned RADIUS_W  = 3 * COORD_W;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned CAND_W    = 8;
  localparam int unsigned DONE_W    = 16;

  localparam logic [MODE_W-1:0] MODE_A   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_AB  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_AXB = 2'b10;
  localparam logic [MODE_W-1:0] MODE_TWO = 2'b11;

  // Job payload as stored in the queue (tag is appended separately).
  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_VALID,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous job queue with registered full/empty flags.
// Head entry is presented combinationally from the storage array.
module set_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full queue is only legal when the head leaves in the same cycle.
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/set_host.sv
// Host-side driver for the SET candidate-counting engine: queues jobs, launches
// them one at a time, collects or times out the response and hands it downstream.
module set_host
  import set_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [CENTRAL_W-1:0] job_central,
  input  logic [RADIUS_W-1:0]  job_radius,
  input  logic [MODE_W-1:0]    job_mode,
  input  logic [TAG_W-1:0]     job_tag,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CAND_W-1:0]    res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_timeout,
  output logic [DONE_W-1:0]    jobs_done
);

  localparam int unsigned JOB_W    = $bits(job_t);
  localparam int unsigned FIFO_W   = JOB_W + TAG_W;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT) + 1;
  // The counter expires when its next value would reach TIMEOUT-1.
  localparam int unsigned TMO_LAST = TIMEOUT - 2;

  state_t            state;
  state_t            state_nxt;
  logic [FIFO_W-1:0] wr_data;
  logic [FIFO_W-1:0] rd_data;
  job_t              head_job;
  logic [TAG_W-1:0]  head_tag;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              res_load;
  logic              res_tmo;
  logic              res_done;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              tmo_hit;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [TAG_W-1:0]  tag_q;

  assign wr_data   = {job_central, job_radius, job_mode, job_tag};
  assign head_job  = rd_data[FIFO_W-1:TAG_W];
  assign head_tag  = rd_data[TAG_W-1:0];
  assign job_ready = !fifo_full;
  assign tmo_hit   = (tmo_cnt == CNT_W'(TMO_LAST));

  set_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (job_valid && job_ready),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    res_load  = 1'b0;
    res_tmo   = 1'b0;
    res_done  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !set_busy && !res_valid) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_inc = 1'b1;
        if (set_valid) begin
          res_load  = 1'b1;
          state_nxt = ST_RESULT;
        end else if (tmo_hit) begin
          res_load  = 1'b1;
          res_tmo   = 1'b1;
          state_nxt = ST_RESULT;
        end else if (set_busy) begin
          state_nxt = ST_WAIT_VALID;
        end
      end
      ST_WAIT_VALID: begin
        cnt_inc = 1'b1;
        if (set_valid) begin
          res_load  = 1'b1;
          state_nxt = ST_RESULT;
        end else if (tmo_hit) begin
          res_load  = 1'b1;
          res_tmo   = 1'b1;
          state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Launch registers: loaded on pop, strobe lasts exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_en      <= 1'b0;
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
      tag_q       <= '0;
    end else begin
      set_en <= pop;
      if (pop) begin
        set_central <= head_job.central;
        set_radius  <= head_job.radius;
        set_mode    <= head_job.mode;
        tag_q       <= head_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (cnt_clr) begin
      tmo_cnt <= '0;
    end else if (cnt_inc) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Result register holds steady until the downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_timeout   <= 1'b0;
      jobs_done     <= '0;
    end else if (res_load) begin
      res_valid     <= 1'b1;
      res_candidate <= res_tmo ? '0 : set_candidate;
      res_tag       <= tag_q;
      res_timeout   <= res_tmo;
    end else if (res_done) begin
      res_valid <= 1'b0;
      jobs_done <= jobs_done + DONE_W'(1);
    end
  end

endmodule
